machine_controller: RTL and testbench
=====================================

// Module: machine_controller
// PURPOSE
//  Fetch/execute sequencer of the simple RISC CPU. An 8-state cycle drives the PC, IR, accumulator,
//  memory read/write strobes and the data-bus output gate.
//  Byte 0 -> IR[15:8]; byte 1 -> IR[7:0]; then executes the 3-bit opcode IR presents.
//  Sits between the clock generator (ena) and the datapath; sole owner of every datapath strobe.
// PARAMETERS
//  OPCODE_W   3   opcode width; fixed by ISA, any other value is an elaboration error
// PORTS
//  clk          in   1         system clock, all state on rising edge
//  rst          in   1         synchronous, active-high reset
//  ena          in   1         run enable from clock generator; low = park in S0
//  opcode       in   OPCODE_W  opcode from instruction register (IR[15:13])
//  zero         in   1         accumulator == 0 flag
//  load_ir      out  1         IR capture enable (IR en)
//  rd           out  1         memory read strobe
//  wr           out  1         memory write strobe
//  inc_pc       out  1         program counter +1
//  load_pc      out  1         PC <= IR address field
//  load_acc     out  1         accumulator <= ALU result
//  datactl_ena  out  1         drive accumulator onto data bus
//  halt         out  1         CPU halted
// BEHAVIOUR
//  Opcodes: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7. ALU ops = ADD/AND/XOR/LDA.
//  3-bit state register S0..S7, plus sticky halted flag. Outputs are combinational from (state, opcode, zero, halted).
//  Unlisted outputs are 0.
//  Reset: state=S0, halted=0, all outputs 0 in the cycle after rst sampled high. rst has priority over ena.
//  ena=0 (not halted): next state S0, all outputs forced 0 this cycle. IR sees load_ir=0, so its byte phase restarts.
//  S0: load_ir, rd, inc_pc                      (high byte)
//  S1: load_ir, rd, inc_pc                      (low byte)
//  S2: idle
//  S3: HLT -> halt=1, set halted; else idle
//  S4: ALU -> rd;  JMP -> load_pc;  STO -> datactl_ena
//  S5: ALU -> rd, load_acc;  SKZ&zero -> inc_pc;  JMP -> load_pc;  STO -> datactl_ena, wr
//  S6: STO -> datactl_ena;  else idle
//  S7: SKZ&zero -> inc_pc;  else idle
//  Transitions: Sk -> S(k+1) each enabled cycle; S7 -> S0 (wrap). One instruction = 8 cycles.
//  opcode/zero are sampled only in S3..S7. They are assumed stable from S2 on.
//  SKZ skips one 16-bit word, i.e. two inc_pc pulses (S5, S7).
//  Halted: state frozen at S0, halt=1, all other outputs 0, ena ignored. Exits only by rst.
//  Invariants: wr and rd never both 1; wr only while datactl_ena=1; load_pc and inc_pc never both 1.
// CONFIGURATION
//  MC_HALT_RESUME_EN defined: adds input `resume` (1 bit). resume=1 while halted clears halted;
//   next cycle is S0 with normal fetch, PC continues after the HLT word. resume ignored when not halted.
//  Undefined: no resume port; halt is left only by rst.
// STRUCTURE
//  cpu_pkg: opcode localparams (OP_HLT..OP_JMP), state encoding S0..S7, OPCODE_W.
//  Sub-module mc_opcode_decode: opcode -> one-hot flags (is_hlt, is_skz, is_alu, is_sto, is_jmp).
//  FSM and output decode live in machine_controller.
// TESTING
//  1 rst high 2 cycles, ena=1, opcode=ADD -> S0 outputs load_ir=rd=inc_pc=1; S5 rd=load_acc=1; back to S0 at cycle 8.
//  2 opcode=STO -> datactl_ena in S4..S6, wr=1 only in S5; rd=0 in S4..S7.
//  3 opcode=SKZ: zero=1 -> inc_pc in S5 and S7 (4 total per instr); zero=0 -> only S0,S1 pulses.
//  4 opcode=JMP -> load_pc=1 in S4,S5; inc_pc=0 in S2..S7.
//  5 opcode=HLT -> halt=1 from S3; state parks; 20 cycles later still halt=1, no strobes; rst clears.
//  6 ena dropped in S4 -> outputs 0 that cycle, state S0 next; ena high -> fresh fetch from S0.
//  Every test checks the invariants (no rd&wr, no load_pc&inc_pc) each cycle.
//  With MC_HALT_RESUME_EN, also check: pulse resume while halted -> S0 fetch next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC CPU control path: opcode values,
// the 8-phase state encoding and the opcode width.
package cpu_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
        S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
    } state_e;

    // Every datapath strobe the controller owns, grouped so the output
    // decode can clear them all with a single default.
    typedef struct packed {
        logic load_ir;
        logic rd;
        logic wr;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic datactl_ena;
        logic halt;
    } mc_out_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Opcode to one-hot class flags. LDA is grouped with the ALU ops because
// it shares their operand-read / accumulator-load timing.
module mc_opcode_decode
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 3
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic                is_hlt_o,
    output logic                is_skz_o,
    output logic                is_alu_o,
    output logic                is_sto_o,
    output logic                is_jmp_o
);

    // Pure decode of the instruction class
    always_comb begin
        is_hlt_o = (opcode_i == OP_HLT);
        is_skz_o = (opcode_i == OP_SKZ);
        is_alu_o = (opcode_i == OP_ADD) || (opcode_i == OP_AND) ||
                   (opcode_i == OP_XOR) || (opcode_i == OP_LDA);
        is_sto_o = (opcode_i == OP_STO);
        is_jmp_o = (opcode_i == OP_JMP);
    end

endmodule

// File: rtl/machine_controller.sv
// Fetch/execute sequencer: an 8-phase cycle (two fetch phases, one idle,
// five execute phases) plus a sticky halted flag.
// Optional feature macro: MC_HALT_RESUME_EN adds a `resume` input that
// releases the halted state without a reset.
module machine_controller #(
    parameter int OPCODE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
`ifdef MC_HALT_RESUME_EN
    input  logic                resume,
`endif
    output logic                load_ir,
    output logic                rd,
    output logic                wr,
    output logic                inc_pc,
    output logic                load_pc,
    output logic                load_acc,
    output logic                datactl_ena,
    output logic                halt
);
    import cpu_pkg::*;

    // The ISA fixes the opcode field; any other width is a build error.
    if (OPCODE_W != cpu_pkg::OPCODE_W) begin : g_bad_opcode_w
        $error("machine_controller: OPCODE_W must be 3");
    end

    state_e  state_q, state_d;
    logic    halted_q, halted_d;
    mc_out_t out;

    logic is_hlt, is_skz, is_alu, is_sto, is_jmp;

    mc_opcode_decode #(.OPCODE_W(OPCODE_W)) u_dec (
        .opcode_i (opcode),
        .is_hlt_o (is_hlt),
        .is_skz_o (is_skz),
        .is_alu_o (is_alu),
        .is_sto_o (is_sto),
        .is_jmp_o (is_jmp)
    );

    // State register and sticky halt flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Next state: halted parks at S0, ena low restarts the fetch, HLT in S3
    // jumps straight to the parked S0, otherwise walk the ring S0..S7.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (halted_q) begin
            state_d = S0;
`ifdef MC_HALT_RESUME_EN
            if (resume) halted_d = 1'b0;
`endif
        end else if (!ena) begin
            state_d = S0;
        end else if (state_q == S3 && is_hlt) begin
            state_d  = S0;
            halted_d = 1'b1;
        end else begin
            state_d = state_e'(state_q + 3'd1);
        end
    end

    // Strobe decode; rst and ena-low both blank every strobe for the cycle
    always_comb begin
        out = '0;
        if (!rst) begin
            if (halted_q) begin
                out.halt = 1'b1;
            end else if (ena) begin
                case (state_q)
                    S0, S1: begin
                        out.load_ir = 1'b1;
                        out.rd      = 1'b1;
                        out.inc_pc  = 1'b1;
                    end
                    S3: out.halt = is_hlt;
                    S4: begin
                        out.rd          = is_alu;
                        out.load_pc     = is_jmp;
                        out.datactl_ena = is_sto;
                    end
                    S5: begin
                        out.rd          = is_alu;
                        out.load_acc    = is_alu;
                        out.inc_pc      = is_skz & zero;
                        out.load_pc     = is_jmp;
                        out.datactl_ena = is_sto;
                        out.wr          = is_sto;
                    end
                    S6: out.datactl_ena = is_sto;
                    S7: out.inc_pc      = is_skz & zero;
                    default: ;
                endcase
            end
        end
    end

    assign load_ir     = out.load_ir;
    assign rd          = out.rd;
    assign wr          = out.wr;
    assign inc_pc      = out.inc_pc;
    assign load_pc     = out.load_pc;
    assign load_acc    = out.load_acc;
    assign datactl_ena = out.datactl_ena;
    assign halt        = out.halt;

endmodule

// File: tb/tb_machine_controller.sv
// Self-checking bench for machine_controller. Expected strobes come from a
// per-opcode behavioural table and are queued as stimulus is applied.
module tb_machine_controller;

    logic clk = 1'b0;
    logic rst, ena, zero, resume;
    logic [2:0] opcode;
    logic load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;

    int n_chk  = 0;
    int n_pass = 0;

    int mstate  = 0;
    bit mhalted = 1'b0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    machine_controller dut (
        .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
`ifdef MC_HALT_RESUME_EN
        .resume(resume),
`endif
        .load_ir(load_ir), .rd(rd), .wr(wr), .inc_pc(inc_pc),
        .load_pc(load_pc), .load_acc(load_acc),
        .datactl_ena(datactl_ena), .halt(halt)
    );

    // bit order {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt}
    function automatic logic [7:0] exp_out(logic r, logic e, logic [2:0] op, logic z);
        if (r) return 8'h00;
        if (mhalted) return 8'b0000_0001;
        if (!e) return 8'h00;
        if (mstate < 2) return 8'b1101_0000;
        case (op)
            3'd0: return (mstate == 3) ? 8'b0000_0001 : 8'h00;
            3'd1: return ((mstate == 5 || mstate == 7) && z) ? 8'b0001_0000 : 8'h00;
            3'd2, 3'd3, 3'd4, 3'd5:
                return (mstate == 4) ? 8'b0100_0000 :
                       (mstate == 5) ? 8'b0100_0100 : 8'h00;
            3'd6:
                return (mstate == 5) ? 8'b0010_0010 :
                       (mstate == 4 || mstate == 6) ? 8'b0000_0010 : 8'h00;
            default:
                return (mstate == 4 || mstate == 5) ? 8'b0000_1000 : 8'h00;
        endcase
    endfunction

    task automatic advance(input logic r, input logic e, input logic [2:0] op, input logic res);
        if (r) begin
            mstate = 0; mhalted = 1'b0;
        end else if (mhalted) begin
            mstate = 0;
`ifdef MC_HALT_RESUME_EN
            if (res) mhalted = 1'b0;
`endif
        end else if (!e) begin
            mstate = 0;
        end else if (mstate == 3 && op == 3'd0) begin
            mstate = 0; mhalted = 1'b1;
        end else begin
            mstate = (mstate + 1) % 8;
        end
    endtask

    // One clock: apply inputs, queue the expectation, sample mid-cycle.
    task automatic cyc(input logic r, input logic e, input logic [2:0] op, input logic z,
                       input logic res, output logic [7:0] o, output logic [7:0] x);
        rst = r; ena = e; opcode = op; zero = z; resume = res;
        exp_q.push_back(exp_out(r, e, op, z));
        #2;
        o = {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt};
        x = exp_q.pop_front();
        advance(r, e, op, res);
        @(posedge clk); #1;
    endtask

    // Structural invariants, checked on every active cycle
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_chk++;
            if ((rd & wr) !== 1'b0 || (load_pc & inc_pc) !== 1'b0 || (wr & ~datactl_ena) !== 1'b0)
                $display("FAIL invariant t=%0t: rd=%b wr=%b ld_pc=%b inc_pc=%b dctl=%b required no conflict",
                         $time, rd, wr, load_pc, inc_pc, datactl_ena);
            else n_pass++;
        end
    end

    task automatic test_reset();
        logic [7:0] o, x;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, o, x);
            n_chk++;
            if (o !== 8'h00) $display("FAIL reset cyc%0d: got %b required 00000000", i, o);
            else n_pass++;
        end
    endtask

    task automatic test_alu();
        logic [7:0] o, x;
        for (int op = 2; op <= 5; op++)
            for (int s = 0; s < 8; s++) begin
                cyc(1'b0, 1'b1, 3'(op), s[0], 1'b0, o, x);
                n_chk++;
                if (o !== x) $display("FAIL alu op%0d s%0d: got %b required %b", op, s, o, x);
                else n_pass++;
            end
    endtask

    task automatic test_sto();
        logic [7:0] o, x;
        for (int s = 0; s < 8; s++) begin
            cyc(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL sto s%0d: got %b required %b", s, o, x);
            else n_pass++;
        end
    endtask

    task automatic test_skz();
        logic [7:0] o, x;
        int pulses;
        for (int z = 1; z >= 0; z--) begin
            pulses = 0;
            for (int s = 0; s < 8; s++) begin
                cyc(1'b0, 1'b1, 3'd1, z[0], 1'b0, o, x);
                pulses += int'(o[4]);
                n_chk++;
                if (o !== x) $display("FAIL skz z%0d s%0d: got %b required %b", z, s, o, x);
                else n_pass++;
            end
            n_chk++;
            if (pulses !== (z ? 4 : 2))
                $display("FAIL skz_count z%0d: got %0d required %0d", z, pulses, z ? 4 : 2);
            else n_pass++;
        end
    endtask

    task automatic test_jmp();
        logic [7:0] o, x;
        for (int s = 0; s < 8; s++) begin
            cyc(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL jmp s%0d: got %b required %b", s, o, x);
            else n_pass++;
        end
    endtask

    task automatic test_ena_drop();
        logic [7:0] o, x;
        for (int s = 0; s < 13; s++) begin
            cyc(1'b0, (s != 4), 3'd2, 1'b0, 1'b0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL ena_drop c%0d: got %b required %b", s, o, x);
            else n_pass++;
        end
        // after the drop at c4 the restart covers c5..c12, so c13 is a fresh S0
        cyc(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, o, x);
        n_chk++;
        if (o !== 8'b1101_0000) $display("FAIL ena_refetch: got %b required 11010000", o);
        else n_pass++;
        for (int s = 1; s < 8; s++) cyc(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, o, x);
    endtask

    task automatic test_back_to_back();
        logic [7:0] o, x;
        logic [2:0] op;
        logic z;
        for (int n = 0; n < 6; n++) begin
            op = 3'($urandom_range(1, 7));
            z  = 1'($urandom_range(0, 1));
            for (int s = 0; s < 8; s++) begin
                cyc(1'b0, 1'b1, op, z, 1'b0, o, x);
                n_chk++;
                if (o !== x) $display("FAIL b2b op%0d s%0d: got %b required %b", op, s, o, x);
                else n_pass++;
            end
        end
    endtask

    task automatic test_halt();
        logic [7:0] o, x;
        for (int s = 0; s < 24; s++) begin
            cyc(1'b0, (s < 4) ? 1'b1 : 1'($urandom_range(0, 1)), 3'd0, 1'b0, 1'b0, o, x);
            n_chk++;
            if (o !== x) $display("FAIL halt c%0d: got %b required %b", s, o, x);
            else n_pass++;
        end
        n_chk++;
        if (o !== 8'b0000_0001) $display("FAIL halt_park: got %b required 00000001", o);
        else n_pass++;
        cyc(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, o, x);
        cyc(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, o, x);
        n_chk++;
        if (o !== 8'b1101_0000) $display("FAIL halt_rst_fetch: got %b required 11010000", o);
        else n_pass++;
        for (int s = 1; s < 8; s++) cyc(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, o, x);
    endtask

`ifdef MC_HALT_RESUME_EN
    task automatic test_resume();
        logic [7:0] o, x;
        for (int s = 0; s < 10; s++) begin
            cyc(1'b0, 1'b1, 3'd0, 1'b0, (s == 7), o, x);
            n_chk++;
            if (o !== x) $display("FAIL resume c%0d: got %b required %b", s, o, x);
            else n_pass++;
        end
        n_chk++;
        if (o !== 8'b1101_0000) $display("FAIL resume_fetch: got %b required 11010000", o);
        else n_pass++;
        cyc(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, o, x);
    endtask
`endif

    initial begin
        rst = 1'b1; ena = 1'b1; opcode = 3'd2; zero = 1'b0; resume = 1'b0;
        test_reset();
        test_alu();
        test_sto();
        test_skz();
        test_jmp();
        test_ena_drop();
        test_back_to_back();
        test_halt();
`ifdef MC_HALT_RESUME_EN
        test_resume();
`endif
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
